// File: rtl/shift_add_pkg.sv
// Shared types and helpers for the bit-serial shift-add multiplier.
// SHIFT_ADD_SAT_EN (in the top) selects saturating vs wrapping output.
package shift_add_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sa_state_t;

    localparam int SA_WIDTH = 32;
    localparam int SA_CW    = 11;
    localparam int ACC_W    = SA_WIDTH + SA_CW;

    function automatic int acc_width(input int width, input int cw);
        return width + cw;
    endfunction

    // Index of the highest set bit; 0 for a zero value.
    function automatic int msb_index(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int b = 0; b < 64; b++)
            if (v[b]) idx = b;
        return idx;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration: conditionally accumulate, shift multiplicand up, coefficient down.
module shift_add_step #(
    parameter int AW = 43,
    parameter int CW = 11
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] mcand,
    input  logic [CW-1:0] coef,
    output logic [AW-1:0] acc_nxt,
    output logic [AW-1:0] mcand_nxt,
    output logic [CW-1:0] coef_nxt,
    output logic          last
);

    assign acc_nxt   = coef[0] ? acc + mcand : acc;
    assign mcand_nxt = mcand << 1;
    assign coef_nxt  = coef >> 1;
    // No set bits left above the one just consumed: the product is complete.
    assign last      = (coef_nxt == '0);

endmodule

// File: rtl/shift_add_serial_mult.sv
// Runtime-coefficient bit-serial multiplier with valid/ready on both sides.
// Define SHIFT_ADD_SAT_EN to saturate o_data0 on overflow instead of wrapping.
module shift_add_serial_mult
    import shift_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [CW-1:0]    i_coef,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data0,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int AW = acc_width(WIDTH, CW);

    sa_state_t      state, state_nxt;
    logic [AW-1:0]  mcand, acc;
    logic [CW-1:0]  coef_r;
    logic [AW-1:0]  acc_nxt, mcand_nxt;
    logic [CW-1:0]  coef_nxt;
    logic           last;
    logic           accept;

    shift_add_step #(.AW(AW), .CW(CW)) u_step (
        .acc       (acc),
        .mcand     (mcand),
        .coef      (coef_r),
        .acc_nxt   (acc_nxt),
        .mcand_nxt (mcand_nxt),
        .coef_nxt  (coef_nxt),
        .last      (last)
    );

    assign o_ready = (state == IDLE) | ((state == DONE) & i_ready);
    assign accept  = i_valid & o_ready;
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE: begin
                if (accept)       state_nxt = BUSY;
                else if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            coef_r <= '0;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand  <= {{CW{1'b0}}, i_data0};
                coef_r <= i_coef;
                acc    <= '0;
            end else if (state == BUSY) begin
                mcand  <= mcand_nxt;
                coef_r <= coef_nxt;
                acc    <= acc_nxt;
            end
        end
    end

    // acc is frozen while DONE, so the outputs stay stable until consumed.
    assign o_ovf = |acc[AW-1:WIDTH];

`ifdef SHIFT_ADD_SAT_EN
    assign o_data0 = o_ovf ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
`else
    assign o_data0 = acc[WIDTH-1:0];
`endif

endmodule
